// File: rtl/fetch_unit_pkg.sv
// Shared pipeline package: ALU op encoding plus the fetch-stage entry type
// and the canonical NOP word handed to decode when no instruction is valid.
package fetch_unit_pkg;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_AND  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_XOR  = 4'd4,
      ALU_SLL  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_SLT  = 4'd8,
      ALU_SLTU = 4'd9
   } alu_op_e;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer between imem responses and decode: circular FIFO of
// fetch_entry_t with synchronous flush; head is read straight from storage.
module fetch_fifo
   import fetch_unit_pkg::*;
#(
   parameter int DEPTH = 2,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             push,
   input  fetch_entry_t     push_data,
   input  logic             pop,
   output logic [CNT_W-1:0] count,
   output fetch_entry_t     head,
   output logic             empty,
   output logic             full
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   fetch_entry_t     mem_q [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q;
   logic [PTR_W-1:0] wr_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             do_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign do_pop = pop && !empty;
   assign count  = count_q;
   assign empty  = (count_q == '0);
   assign full   = (count_q == CNT_W'(DEPTH));
   assign head   = mem_q[rd_ptr_q];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push)   wr_ptr_q <= ptr_inc(wr_ptr_q);
         if (do_pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
         count_q <= count_q + CNT_W'(push) - CNT_W'(do_pop);
      end
   end

   // Storage needs no reset: head is only consumed while the FIFO is non-empty.
   always_ff @(posedge clk) begin
      if (push && !flush) mem_q[wr_ptr_q] <= push_data;
   end

   assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !pop));

endmodule

// File: rtl/fetch_unit.sv
// IF stage: owns the PC, issues in-order imem word requests under a credit
// limit of DEPTH, buffers responses and feeds decode. Optional FETCH_PERF_EN.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_gnt_i,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   input  logic        stall_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic [31:0] instr_o,
   output logic [31:0] pc_o,
   output logic        instr_valid_o,
   output logic [31:0] fetch_cnt_o,
   output logic [31:0] bubble_cnt_o
);

   localparam int CNT_W = $clog2(DEPTH + 1);

   // Handshakes: a request transfers on a cycle with imem_req_o && imem_gnt_i;
   // responses transfer on imem_rvalid_i alone (in order, never backpressured);
   // decode consumes on instr_valid_o && !stall_i.
   logic [31:0]      pc_q;
   logic [31:0]      resp_pc_q;
   logic [CNT_W-1:0] outstanding_q;
   logic [CNT_W-1:0] outstanding_next;
   logic [CNT_W-1:0] drop_cnt_q;
   logic [CNT_W-1:0] fifo_count;
   logic [CNT_W:0]   in_flight;
   logic             grant;
   logic             rsp;
   logic             push;
   logic             pop;
   logic             fifo_empty;
   logic             fifo_full;
   fetch_entry_t     head;
   fetch_entry_t     push_data;
   logic             unused_ok;

   assign in_flight   = {1'b0, fifo_count} + {1'b0, outstanding_q};
   assign imem_req_o  = rst_n && !redirect_i && (in_flight < (CNT_W+1)'(DEPTH));
   assign imem_addr_o = pc_q;
   assign grant       = imem_req_o && imem_gnt_i;

   // A response with nothing outstanding (e.g. left over from before reset) is ignored.
   assign rsp              = imem_rvalid_i && (outstanding_q != '0);
   assign outstanding_next = outstanding_q + CNT_W'(grant) - CNT_W'(rsp);
   assign push             = rsp && !redirect_i && (drop_cnt_q == '0);
   assign push_data        = '{pc: resp_pc_q, instr: imem_rdata_i};
   assign pop              = instr_valid_o && !stall_i;

   assign unused_ok = ^{redirect_pc_i[1:0], fifo_full};

   fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (redirect_i),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .count     (fifo_count),
      .head      (head),
      .empty     (fifo_empty),
      .full      (fifo_full)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q          <= RESET_PC;
         resp_pc_q     <= RESET_PC;
         outstanding_q <= '0;
         drop_cnt_q    <= '0;
      end else begin
         outstanding_q <= outstanding_next;
         if (redirect_i) begin
            // Everything still in flight belongs to the old path, older drops included.
            pc_q       <= {redirect_pc_i[31:2], 2'b00};
            resp_pc_q  <= {redirect_pc_i[31:2], 2'b00};
            drop_cnt_q <= outstanding_next;
         end else begin
            if (grant) pc_q <= pc_q + 32'd4;
            if (rsp) begin
               if (drop_cnt_q != '0) drop_cnt_q <= drop_cnt_q - 1'b1;
               else                  resp_pc_q  <= resp_pc_q + 32'd4;
            end
         end
      end
   end

   assign instr_valid_o = !fifo_empty;
   assign instr_o       = instr_valid_o ? head.instr : NOP_INSTR;
   assign pc_o          = instr_valid_o ? head.pc : 32'h0;

`ifdef FETCH_PERF_EN
   logic [31:0] fetch_cnt_q;
   logic [31:0] bubble_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_cnt_q  <= '0;
         bubble_cnt_q <= '0;
      end else begin
         if (pop) fetch_cnt_q <= fetch_cnt_q + 32'd1;
         if (!stall_i && !instr_valid_o && !redirect_i) bubble_cnt_q <= bubble_cnt_q + 32'd1;
      end
   end

   assign fetch_cnt_o  = fetch_cnt_q;
   assign bubble_cnt_o = bubble_cnt_q;
`else
   assign fetch_cnt_o  = 32'h0;
   assign bubble_cnt_o = 32'h0;
`endif

   assert property (@(posedge clk) disable iff (!rst_n)
                    !(imem_rvalid_i && (outstanding_q == '0)));

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed steps then random traffic, checked against an
// in-order delivery model (expected PC stream) and a word-per-address imem model.
module tb_fetch_unit;
   import fetch_unit_pkg::*;

   localparam int          DEPTH    = 2;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk;
   logic        rst_n;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_gnt_i;
   logic        imem_rvalid_i;
   logic [31:0] imem_rdata_i;
   logic        stall_i;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;
   logic [31:0] instr_o;
   logic [31:0] pc_o;
   logic        instr_valid_o;
   logic [31:0] fetch_cnt_o;
   logic [31:0] bubble_cnt_o;

   fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .imem_req_o    (imem_req_o),
      .imem_addr_o   (imem_addr_o),
      .imem_gnt_i    (imem_gnt_i),
      .imem_rvalid_i (imem_rvalid_i),
      .imem_rdata_i  (imem_rdata_i),
      .stall_i       (stall_i),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i),
      .instr_o       (instr_o),
      .pc_o          (pc_o),
      .instr_valid_o (instr_valid_o),
      .fetch_cnt_o   (fetch_cnt_o),
      .bubble_cnt_o  (bubble_cnt_o)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          total = 0;
   int          bad   = 0;
   logic [31:0] exp_q[$];   // PCs decode must see, in order
   logic [31:0] resp_q[$];  // granted addresses still owed a response
   logic [31:0] salt;
   int unsigned m_fetch;
   int unsigned m_bubble;
   logic        s_req, s_valid;
   logic [31:0] s_addr, s_pc, s_instr;
   logic        pend_req;
   logic [31:0] pend_addr;
   logic [31:0] hold_pc, hold_instr;
   int          n;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ salt;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic refill(input logic [31:0] start);
      exp_q.delete();
      for (int i = 0; i < 64; i++) exp_q.push_back(start + 32'(4 * i));
   endtask

   task automatic check_perf();
      #1;
`ifdef FETCH_PERF_EN
      check("fetch_cnt", fetch_cnt_o, m_fetch);
      check("bubble_cnt", bubble_cnt_o, m_bubble);
`else
      check("fetch_cnt_off", fetch_cnt_o, 32'h0);
      check("bubble_cnt_off", bubble_cnt_o, 32'h0);
`endif
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0;
      stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0;
      imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0;
      #1;
      check("rst_req", 32'(imem_req_o), 0);
      check("rst_addr", imem_addr_o, RESET_PC);
      check("rst_valid", 32'(instr_valid_o), 0);
      check("rst_instr", instr_o, NOP_INSTR);
      check("rst_pc", pc_o, 32'h0);
      check("rst_fetch_cnt", fetch_cnt_o, 32'h0);
      check("rst_bubble_cnt", bubble_cnt_o, 32'h0);
      resp_q.delete();
      refill(RESET_PC);
      pend_req = 1'b0; pend_addr = 32'h0;
      m_fetch = 0; m_bubble = 0;
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
   endtask

   // driver: one clock cycle; rmode 0 = no response, 1 = respond when owed, 2 = random
   task automatic tick(input bit st, input bit rd, input logic [31:0] rpc, input bit g,
                       input int rmode);
      logic        rv;
      logic [31:0] exp_pc;
      @(negedge clk);
      rv = (resp_q.size() > 0) && (rmode == 1 || (rmode == 2 && $urandom_range(0, 1) == 1));
      stall_i = st; redirect_i = rd; redirect_pc_i = rpc; imem_gnt_i = g;
      imem_rvalid_i = rv;
      imem_rdata_i = rv ? mem_word(resp_q[0]) : $urandom;
      #1;
      s_req = imem_req_o; s_addr = imem_addr_o; s_valid = instr_valid_o;
      s_pc = pc_o; s_instr = instr_o;
      if (pend_req && !rd) begin
         check("req_hold", 32'(s_req), 1);
         check("addr_hold", s_addr, pend_addr);
      end
      if (rd) check("req_on_redirect", 32'(s_req), 0);
      check("credit", 32'(resp_q.size() <= DEPTH), 1);
      if (s_valid) begin
         if (!st) begin
            exp_pc = exp_q.pop_front();
            check("deliver_pc", s_pc, exp_pc);
            check("deliver_instr", s_instr, mem_word(exp_pc));
            m_fetch++;
            if (exp_q.size() < 8) for (int i = 0; i < 64; i++) exp_q.push_back(exp_q[$] + 32'd4);
         end
      end else begin
         check("idle_instr", s_instr, NOP_INSTR);
         check("idle_pc", s_pc, 32'h0);
         if (!st && !rd) m_bubble++;
      end
      if (rv) void'(resp_q.pop_front());
      if (s_req && g) resp_q.push_back(s_addr);
      if (rd) refill({rpc[31:2], 2'b00});
      pend_req  = s_req && !g;
      pend_addr = s_addr;
      @(posedge clk);
   endtask

   initial begin
      rst_n = 1'b0;
      salt = $urandom;
      apply_reset();

      // grant withheld: request and address must hold
      for (int i = 0; i < 5; i++) begin
         tick(0, 0, 32'h0, 0, 1);
         check("nognt_req", 32'(s_req), 1);
         check("nognt_addr", s_addr, RESET_PC);
         check("nognt_valid", 32'(s_valid), 0);
      end

      // streaming: grant at cycle 0, first instruction at cycle 2
      tick(0, 0, 32'h0, 1, 1);
      check("stream_addr0", s_addr, 32'h0);
      check("stream_valid0", 32'(s_valid), 0);
      tick(0, 0, 32'h0, 1, 1);
      check("stream_req1", 32'(s_req), 1);
      check("stream_addr1", s_addr, 32'h4);
      check("stream_valid1", 32'(s_valid), 0);
      tick(0, 0, 32'h0, 1, 1);
      check("stream_first_valid", 32'(s_valid), 1);
      check("stream_first_pc", s_pc, 32'h0);
      for (int i = 0; i < 20; i++) tick(0, 0, 32'h0, 1, 1);
      check_perf();

      // stall: head holds, fetching stops once credits are used up
      n = 0;
      do begin tick(1, 0, 32'h0, 1, 1); n++; end while (!s_valid && n < 10);
      check("stall_fill_valid", 32'(s_valid), 1);
      hold_pc = s_pc; hold_instr = s_instr;
      for (int i = 0; i < 4; i++) begin
         tick(1, 0, 32'h0, 1, 1);
         check("stall_valid", 32'(s_valid), 1);
         check("stall_pc", s_pc, hold_pc);
         check("stall_instr", s_instr, hold_instr);
      end
      check("stall_req_off", 32'(s_req), 0);
      for (int i = 0; i < 10; i++) tick(0, 0, 32'h0, 1, 1);

      // redirect with two requests outstanding
      n = 0;
      do begin tick(0, 0, 32'h0, 1, 0); n++; end while (resp_q.size() < 2 && n < 10);
      check("redir_setup", 32'(resp_q.size()), 2);
      tick(0, 1, 32'h103, 1, 0);
      tick(0, 0, 32'h0, 1, 0);
      check("redir_addr", s_addr, 32'h100);
      check("redir_valid", 32'(s_valid), 0);
      n = 0;
      do begin tick(0, 0, 32'h0, 1, 1); n++; end while (!s_valid && n < 20);
      check("redir_first_valid", 32'(s_valid), 1);
      check("redir_first_pc", s_pc, 32'h100);

      // redirect coinciding with a response under stall
      n = 0;
      do begin tick(0, 0, 32'h0, 1, 0); n++; end while (resp_q.size() < 2 && n < 10);
      check("redir2_setup", 32'(resp_q.size()), 2);
      tick(1, 1, 32'h200, 1, 1);
      tick(1, 0, 32'h0, 1, 0);
      check("redir2_empty", 32'(s_valid), 0);
      n = 0;
      do begin tick(0, 0, 32'h0, 1, 1); n++; end while (!s_valid && n < 20);
      check("redir2_first_valid", 32'(s_valid), 1);
      check("redir2_first_pc", s_pc, 32'h200);
      check_perf();

      // random traffic with a reset in the middle
      for (int i = 0; i < 1500; i++) begin
         if (i == 700) begin
            check_perf();
            apply_reset();
         end
         tick($urandom_range(0, 3) == 0, $urandom_range(0, 39) == 0, $urandom,
              $urandom_range(0, 2) != 0, 2);
      end
      check_perf();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
